// File: rtl/throw_ctl_pkg.sv
// Shared types and helpers for the projectile throw controller.
// Result codes, FSM states and the wind term.
package throw_ctl_pkg;

  typedef enum logic [1:0] {
    RES_NONE,
    RES_TARGET,
    RES_WALL,
    RES_OUT
  } result_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FLIGHT,
    ST_DONE
  } throw_state_t;

  localparam int WIND_CALM = 50;
  localparam int WIND_BASE = 5;
  localparam int WIND_SPAN = 5;

  // Calm gives zero; any breeze jumps straight to +/-5 then scales to +/-10.
  function automatic logic signed [13:0] wind_term(input logic [6:0] w);
    int wi;
    int t;
    wi = int'(w);
    if (wi < WIND_CALM)
      t = -WIND_BASE - ((WIND_CALM - wi) * WIND_SPAN) / WIND_CALM;
    else if (wi > WIND_CALM)
      t = WIND_BASE + ((wi - WIND_CALM) * WIND_SPAN) / WIND_CALM;
    else
      t = 0;
    return 14'(t);
  endfunction

endpackage

// File: rtl/throw_ctl_tick.sv
// Physics step divider for the throw controller.
// Pulses step on the last count of each DIV-cycle period.
module tick_gen #(
  parameter int DIV = 1300000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic step
);

  localparam int W = $clog2(DIV);
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n || clr)
      cnt <= '0;
    else if (cnt == LAST)
      cnt <= '0;
    else
      cnt <= cnt + W'(1);
  end

  assign step = (cnt == LAST) && !clr;

endmodule

// File: rtl/throw_ctl.sv
// Ballistic projectile controller, one instance per thrower.
// Integrates the arc per tick and reports the collision result.
module throw_ctl
  import throw_ctl_pkg::*;
#(
  parameter int DIR       = 1,
  parameter int TICK_DIV  = 1300000,
  parameter int START_X   = 140,
  parameter int START_Y   = 350,
  parameter int INIT_VY   = 27,
  parameter int GRAVITY   = 1,
  parameter int FORCE_NUM = 18,
  parameter int X_MAX     = 1023,
  parameter int FLOOR_Y   = 190,
  parameter int TGT_XL    = 0,
  parameter int TGT_XR    = 157,
  parameter int TGT_YB    = 243,
  parameter int TGT_YT    = 341,
  parameter int WALL_XL   = 475,
  parameter int WALL_XR   = 549,
  parameter int WALL_YT   = 527
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic               abort,
  input  logic [9:0]         throw_force,
  input  logic [6:0]         wind_force,
  output logic signed [11:0] x_pos,
  output logic signed [11:0] y_pos,
  output logic               busy,
  output logic               hit_target,
  output logic [1:0]         result,
  output logic               throw_done
);

  localparam logic signed [11:0] SX = 12'(START_X);
  localparam logic signed [11:0] SY = 12'(START_Y);
  localparam logic signed [13:0] P_VY = 14'(INIT_VY);
  localparam logic signed [13:0] P_G = 14'(GRAVITY);
  localparam logic signed [13:0] P_XMAX = 14'(X_MAX);
  localparam logic signed [13:0] P_FLR = 14'(FLOOR_Y);
  localparam logic signed [13:0] P_TXL = 14'(TGT_XL);
  localparam logic signed [13:0] P_TXR = 14'(TGT_XR);
  localparam logic signed [13:0] P_TYB = 14'(TGT_YB);
  localparam logic signed [13:0] P_TYT = 14'(TGT_YT);
  localparam logic signed [13:0] P_WXL = 14'(WALL_XL);
  localparam logic signed [13:0] P_WXR = 14'(WALL_XR);
  localparam logic signed [13:0] P_WYT = 14'(WALL_YT);

  throw_state_t state_q, state_d;
  result_t coll, res_q;

  logic signed [11:0] x_q, y_q;
  logic signed [13:0] vx_q, vy_q;
  logic signed [13:0] nx, ny, vx0;
  logic signed [11:0] cx, cy;
  logic hit_q, step;
  logic in_tgt, in_wall, in_out;
  int mag;

  tick_gen #(.DIV(TICK_DIV)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (state_q != ST_FLIGHT),
    .step  (step)
  );

  always_comb begin
    mag = (int'(throw_force) * FORCE_NUM) / 100;
    vx0 = 14'(DIR * mag) + wind_term(wind_force);
  end

  assign nx = {{2{x_q[11]}}, x_q} + vx_q;
  assign ny = {{2{y_q[11]}}, y_q} + vy_q;

  assign in_tgt = (nx >= P_TXL) && (nx <= P_TXR)
               && (ny >= P_TYB) && (ny <= P_TYT);
  assign in_wall = (nx >= P_WXL) && (nx <= P_WXR)
                && (ny >= P_FLR) && (ny <= P_WYT);
  assign in_out = (ny <= P_FLR) || nx[13] || (nx > P_XMAX);

  always_comb begin
    coll = RES_NONE;
    if (in_tgt)
      coll = RES_TARGET;
    else if (in_wall)
      coll = RES_WALL;
    else if (in_out)
      coll = RES_OUT;
  end

  // Impact point is pinned back inside the playfield for the sprite.
  assign cx = nx[13] ? '0 : (nx > P_XMAX) ? 12'(X_MAX) : nx[11:0];
  assign cy = (ny < P_FLR) ? 12'(FLOOR_Y) : ny[11:0];

  always_ff @(posedge clk) begin
    if (!rst_n)
      state_q <= ST_IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (enable) state_d = ST_FLIGHT;
      ST_FLIGHT: begin
        if (abort)
          state_d = ST_IDLE;
        else if (step && coll != RES_NONE)
          state_d = ST_DONE;
      end
      ST_DONE:   if (abort || !enable) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy       = (state_q == ST_FLIGHT);
    throw_done = (state_q == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x_q   <= SX;
      y_q   <= SY;
      vx_q  <= '0;
      vy_q  <= '0;
      res_q <= RES_NONE;
      hit_q <= 1'b0;
    end else begin
      hit_q <= 1'b0;
      if (state_d == ST_IDLE) begin
        x_q   <= SX;
        y_q   <= SY;
        res_q <= RES_NONE;
      end else if (state_q == ST_IDLE) begin
        vx_q <= vx0;
        vy_q <= P_VY;
      end else if (state_q == ST_FLIGHT && step) begin
        vy_q <= vy_q - P_G;
        if (coll != RES_NONE) begin
          x_q   <= cx;
          y_q   <= cy;
          res_q <= coll;
          hit_q <= (coll == RES_TARGET);
        end else begin
          x_q <= nx[11:0];
          y_q <= ny[11:0];
        end
      end
    end
  end

  assign x_pos      = x_q;
  assign y_pos      = y_q;
  assign result     = res_q;
  assign hit_target = hit_q;

endmodule

// File: tb/tb_throw_ctl.sv
// Self-checking bench for throw_ctl: closed-form arc model,
// per-cycle compare on two throwers, plus literal spot checks.
module tb_throw_ctl;

  localparam int DIV = 4;
  localparam int SY = 350, VY = 27, G = 1, FN = 18;
  localparam int XM = 1023, FL = 190;
  localparam int WL = 475, WR = 549, WT = 527;

  typedef struct {
    int st;
    int cyc;
    int vx;
    int x;
    int y;
    int res;
    bit hit;
  } ms_t;

  typedef struct {
    int dir;
    int sx;
    int tl;
    int tr;
    int tb;
    int tt;
  } mp_t;

  logic clk = 0;
  logic rst_n, enable, abort;
  logic [9:0] force_v;
  logic [6:0] wind_v;

  logic signed [11:0] x_a, y_a, x_b, y_b;
  logic busy_a, hit_a, done_a, busy_b, hit_b, done_b;
  logic [1:0] res_a, res_b;

  int n_tests = 0;
  int n_fail = 0;

  ms_t ma = '{-1, 0, 0, 0, 0, 0, 1'b0};
  ms_t mb = '{-1, 0, 0, 0, 0, 0, 1'b0};
  mp_t pa = '{1, 140, 0, 157, 243, 341};
  mp_t pb = '{-1, 884, 600, 720, 300, 500};

  always #5 clk = ~clk;

  throw_ctl #(.DIR(1), .TICK_DIV(DIV)) dut_a (
    .clk(clk), .rst_n(rst_n), .enable(enable), .abort(abort),
    .throw_force(force_v), .wind_force(wind_v),
    .x_pos(x_a), .y_pos(y_a), .busy(busy_a), .hit_target(hit_a),
    .result(res_a), .throw_done(done_a)
  );

  throw_ctl #(
    .DIR(-1), .TICK_DIV(DIV), .START_X(884),
    .TGT_XL(600), .TGT_XR(720), .TGT_YB(300), .TGT_YT(500)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .enable(enable), .abort(abort),
    .throw_force(force_v), .wind_force(wind_v),
    .x_pos(x_b), .y_pos(y_b), .busy(busy_b), .hit_target(hit_b),
    .result(res_b), .throw_done(done_b)
  );

  function automatic int wind_of(int w);
    if (w < 50) return -5 - ((50 - w) * 5) / 50;
    if (w > 50) return 5 + ((w - 50) * 5) / 50;
    return 0;
  endfunction

  function automatic ms_t to_idle(ms_t m, mp_t p);
    ms_t n = m;
    n.st = 0; n.x = p.sx; n.y = SY; n.res = 0;
    return n;
  endfunction

  // st: 0 idle, 1 flight, 2 done. Position after k steps in closed form.
  function automatic ms_t mstep(ms_t m, mp_t p, bit rn, bit en,
                                bit ab, int f, int w);
    ms_t n = m;
    int k, nx, ny, r;
    n.hit = 0;
    if (!rn) begin
      n = to_idle(m, p);
      n.cyc = 0; n.hit = 0;
      return n;
    end
    if (m.st == 0) begin
      n = to_idle(m, p);
      n.hit = 0;
      if (en) begin
        n.st = 1; n.cyc = 0;
        n.vx = p.dir * ((f * FN) / 100) + wind_of(w);
      end
    end else if (m.st == 1) begin
      if (ab) begin
        n = to_idle(m, p);
        n.hit = 0;
      end else begin
        n.cyc = m.cyc + 1;
        if (n.cyc % DIV == 0) begin
          k = n.cyc / DIV;
          nx = p.sx + k * m.vx;
          ny = SY + k * VY - G * k * (k - 1) / 2;
          r = 0;
          if (nx >= p.tl && nx <= p.tr && ny >= p.tb && ny <= p.tt) r = 1;
          else if (nx >= WL && nx <= WR && ny >= FL && ny <= WT) r = 2;
          else if (ny <= FL || nx < 0 || nx > XM) r = 3;
          if (r != 0) begin
            n.st = 2; n.res = r; n.hit = (r == 1);
            n.x = nx < 0 ? 0 : (nx > XM ? XM : nx);
            n.y = ny < FL ? FL : ny;
          end else begin
            n.x = nx; n.y = ny;
          end
        end
      end
    end else if (m.st == 2) begin
      if (ab || !en) begin
        n = to_idle(m, p);
        n.hit = 0;
      end
    end
    return n;
  endfunction

  always @(posedge clk) begin
    ma = mstep(ma, pa, rst_n, enable, abort, int'(force_v), int'(wind_v));
    mb = mstep(mb, pb, rst_n, enable, abort, int'(force_v), int'(wind_v));
  end

  task automatic cmp(input string nm, input ms_t m, input int x, input int y,
                     input bit b, input bit h, input int r, input bit d);
    n_tests++;
    if (x != m.x || y != m.y || b != (m.st == 1) || h != m.hit
        || r != m.res || d != (m.st == 2)) begin
      n_fail++;
      $display("FAIL %s t=%0t: got x=%0d y=%0d busy=%0b hit=%0b res=%0d done=%0b, want x=%0d y=%0d busy=%0b hit=%0b res=%0d done=%0b",
               nm, $time, x, y, b, h, r, d,
               m.x, m.y, m.st == 1, m.hit, m.res, m.st == 2);
    end
  endtask

  always @(negedge clk) begin
    if (ma.st >= 0) begin
      cmp("model_a", ma, int'(x_a), int'(y_a), busy_a, hit_a, int'(res_a), done_a);
      cmp("model_b", mb, int'(x_b), int'(y_b), busy_b, hit_b, int'(res_b), done_b);
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic stop_all();
    abort = 1; enable = 0;
    tick(1);
    abort = 0;
  endtask

  int n, ab_at, rs_at;

  initial begin
    rst_n = 0; enable = 0; abort = 0; force_v = 0; wind_v = 50;
    tick(2);
    chk("rst_x", int'(x_a), 140);
    chk("rst_y", int'(y_a), 350);
    chk("rst_busy", int'(busy_a), 0);
    chk("rst_done", int'(done_a), 0);
    chk("rst_res", int'(res_a), 0);
    rst_n = 1;
    tick(1);

    force_v = 100; wind_v = 50; enable = 1;
    tick(4);
    chk("pre_step_x", int'(x_a), 140);
    chk("flight_busy", int'(busy_a), 1);
    tick(1);
    chk("step1_x", int'(x_a), 158);
    chk("step1_y", int'(y_a), 377);
    tick(4);
    chk("step2_x", int'(x_a), 176);
    chk("step2_y", int'(y_a), 403);
    chk("step2_busy", int'(busy_a), 1);
    stop_all();
    chk("abort_x", int'(x_a), 140);
    chk("abort_busy", int'(busy_a), 0);

    wind_v = 100; enable = 1;
    tick(5);
    chk("wind100_x", int'(x_a), 168);
    stop_all();
    wind_v = 0; enable = 1;
    tick(5);
    chk("wind0_x", int'(x_a), 148);
    stop_all();

    force_v = 500; wind_v = 50; enable = 1;
    tick(9);
    chk("tgt_hit", int'(hit_b), 1);
    chk("tgt_res", int'(res_b), 1);
    chk("tgt_done", int'(done_b), 1);
    chk("tgt_x", int'(x_b), 704);
    chk("tgt_y", int'(y_b), 403);
    tick(1);
    chk("tgt_hit_1cyc", int'(hit_b), 0);
    tick(4);
    chk("hold_done", int'(done_b), 1);
    enable = 0;
    tick(1);
    chk("rel_done", int'(done_b), 0);
    chk("rel_res", int'(res_b), 0);
    chk("rel_x", int'(x_b), 884);
    stop_all();

    force_v = 1000; wind_v = 50; enable = 1;
    tick(9);
    chk("wall_res", int'(res_a), 2);
    chk("wall_x", int'(x_a), 500);
    chk("wall_y", int'(y_a), 403);
    stop_all();

    enable = 1;
    tick(8);
    abort = 1; enable = 0;
    tick(1);
    abort = 0;
    chk("abort_coll_done", int'(done_a), 0);
    chk("abort_coll_res", int'(res_a), 0);
    chk("abort_coll_x", int'(x_a), 140);

    force_v = 200; wind_v = 90; enable = 1;
    tick(81);
    chk("out_res", int'(res_a), 3);
    chk("out_x", int'(x_a), 1023);
    chk("out_y", int'(y_a), 700);
    stop_all();

    force_v = 300; wind_v = 50; enable = 1;
    tick(6);
    rst_n = 0;
    tick(1);
    chk("mid_rst_busy", int'(busy_a), 0);
    chk("mid_rst_x", int'(x_a), 140);
    chk("mid_rst_y", int'(y_a), 350);
    rst_n = 1; enable = 0;
    tick(1);

    for (int t = 0; t < 60; t++) begin
      force_v = 10'($urandom_range(0, 1000));
      wind_v = 7'($urandom_range(0, 100));
      ab_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 120)) : -1;
      rs_at = ($urandom_range(0, 11) == 0) ? int'($urandom_range(1, 120)) : -1;
      enable = 1;
      tick(2);
      n = 0;
      while ((busy_a || busy_b) && n < 400) begin
        abort = (n == ab_at);
        rst_n = !(n == rs_at);
        tick(1);
        n++;
      end
      abort = 0; rst_n = 1;
      n_tests++;
      if (n >= 400) begin
        n_fail++;
        $display("FAIL timeout: throw %0d still busy after %0d cycles", t, n);
      end
      tick($urandom_range(0, 4));
      if ($urandom_range(0, 3) == 0) begin
        abort = 1;
        tick(1);
        abort = 0;
      end
      enable = 0;
      tick(2);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/throw_ctl.md
Name: throw_ctl

Overview:
- Parametrised projectile controller; successor to the single-player dog throw controller.
- Serves both players through the DIR parameter, so one module is instantiated per thrower.
- Integrates a ballistic arc per physics tick, applies throw force and wind, and detects target, wall and ground/out-of-bounds collisions.
- Reports a result code with a level handshake to the game FSM; sits between the input/force logic and the sprite/draw path.

Parameters:
- DIR, 1, horizontal throw direction: +1 = rightward, -1 = leftward.
- TICK_DIV, 1300000, clk cycles per physics step (>=2).
- START_X, 140, launch x, world coordinates (origin bottom-left, y up).
- START_Y, 350, launch y.
- INIT_VY, 27, initial vertical velocity, px/step.
- GRAVITY, 1, vy decrement per step.
- FORCE_NUM, 18, force scale: vx_mag = throw_force*FORCE_NUM/100.
- X_MAX, 1023, rightmost legal x; FLOOR_Y, 190, ground level.
- TGT_XL, TGT_XR, TGT_YB, TGT_YT, 0/157/243/341, target box (inclusive).
- WALL_XL, WALL_XR, WALL_YT, 475/549/527, wall box; bottom is FLOOR_Y.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous, active-low reset.
- enable  in  1  level request; a throw starts when enable is seen high in IDLE.
- abort  in  1  cancels flight, returns to IDLE.
- throw_force  in  10  0..1000, sampled at start.
- wind_force  in  7  0..100, 50 = calm, sampled at start.
- x_pos  out  12 signed  projectile x.
- y_pos  out  12 signed  projectile y.
- busy  out  1  high in FLIGHT.
- hit_target  out  1  one-cycle pulse on target impact.
- result  out  2  0 NONE, 1 TARGET, 2 WALL, 3 GROUND/OUT; valid while throw_done is high.
- throw_done  out  1  high in DONE.

Behaviour:
- Reset (rst_n=0 at clk edge):
  - state IDLE; x_pos=START_X, y_pos=START_Y.
  - busy=0, hit_target=0, result=0, throw_done=0; tick counter 0.
- Wind term, computed from the sampled wind w:
  - w<50: wind = -5-((50-w)*5)/50.
  - w>50: wind = 5+((w-50)*5)/50.
  - w=50: wind = 0.
  - Wind is direction-independent; it acts in world x.
- On start, latch vx = DIR*(throw_force*FORCE_NUM/100) + wind. All arithmetic is signed, 14 bits internal.
- IDLE:
  - Outputs held at START; enable=1 -> FLIGHT.
  - Latch vx, vy=INIT_VY; tick counter cleared.
- FLIGHT:
  - Tick counter runs 0..TICK_DIV-1; a step fires on the cycle the count equals TICK_DIV-1, so the first step occurs TICK_DIV cycles after the start edge.
  - Per step: nx=x+vx, ny=y+vy, vy<=vy-GRAVITY.
  - Collisions are checked on (nx,ny) in the same cycle. Priority: target box > wall box > (ny<=FLOOR_Y or nx<0 or nx>X_MAX).
  - On collision: x_pos/y_pos <= nx/ny clamped to [0,X_MAX] and [FLOOR_Y,…]; result set; state -> DONE; hit_target=1 for that one cycle on a target hit.
  - With no collision, outputs update to nx/ny.
- DONE:
  - throw_done=1; position and result held.
  - enable=0 -> IDLE, clearing result and restoring START position.
- abort=1 in FLIGHT or DONE -> IDLE next cycle, with result=0 and no done pulse. abort has priority over a same-cycle collision.
- rst_n=0 mid-flight: full reset at that edge; no pulse.
- enable held high through DONE does not retrigger; it must drop first.

Decomposition:
- vga_pkg gains:
  - result_t enum (RES_NONE, RES_TARGET, RES_WALL, RES_OUT).
  - throw_state_t enum (ST_IDLE, ST_FLIGHT, ST_DONE).
  - WIND_CALM=50.
- Sub-module tick_gen (parameter DIV; inputs clk, rst_n, clr; output step) owns the divider.
- Wind and collision logic stay combinational inside throw_ctl.

Test Plan:
- TICK_DIV=4, force 100, wind 50, DIR=+1, enable rises:
  - Step 1 at cycle 4 -> (158,377); step 2 -> (176,403).
  - busy=1 throughout.
- Same setup, wind 100 vs wind 0: step 1 x = 168 and 148 respectively (vx=28, vx=8).
- DIR=-1, START_X=884, force 500, wind 50, with the target box placed on the path: hit_target pulses exactly 1 cycle, result=1, throw_done=1.
- Default parameters, force 1000 (vx=180): nx>X_MAX or wall entry -> result=3 or 2 respectively, x_pos clamped to ≤1023.
- abort asserted at step 5 -> IDLE next cycle, x_pos=START_X, throw_done never high; a same-cycle collision is ignored.
- enable held high after DONE -> stays DONE; enable low -> IDLE next cycle with result=0. rst_n low mid-flight -> all outputs at reset values next cycle.
